// File: rtl/cfg_scan_pkg.sv
// Shared types and constants for the configuration scan chain.
// No logic; no latency.
// No flow control.
package cfg_scan_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_CHECK = 2'd2,
        ST_PEND  = 2'd3
    } state_e;

    // x^8 + x^2 + x + 1, MSB-first, no reflection
    localparam logic [7:0] CRC8_POLY = 8'h07;

    function automatic int frame_len(input int chain_len, input int crc_w);
        return chain_len + crc_w;
    endfunction

endpackage

// File: rtl/cfg_scan_chain_crc.sv
// Serial MSB-first CRC, one bit per enabled cycle; clr restarts from zero.
// Latency: residue valid the cycle after the last enabled bit.
// No backpressure: accepts a bit on every cycle en is high.
module crc_serial
    import cfg_scan_pkg::*;
#(
    parameter int                 CRC_W = 8,
    parameter logic [CRC_W-1:0]   POLY  = CRC_W'(CRC8_POLY)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    input  logic             data_bit,
    output logic [CRC_W-1:0] crc
);

    logic [CRC_W-1:0] base;
    logic [CRC_W-1:0] crc_nxt;
    logic             fb;

    // clr together with en folds the first bit into a fresh register
    always_comb begin
        base    = clr ? '0 : crc;
        fb      = base[CRC_W-1] ^ data_bit;
        crc_nxt = {base[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            crc <= '0;
        end else if (en) begin
            crc <= crc_nxt;
        end else if (clr) begin
            crc <= '0;
        end
    end

endmodule

// File: rtl/cfg_scan_chain.sv
// Shadow scan register with CRC/length check, committed into active cfg_q.
// Latency: cfg_q updates 2 cycles after scan_en fall when cfg_lock is low.
// Backpressure: cfg_lock holds a checked frame in PEND until released.
module cfg_scan_chain
    import cfg_scan_pkg::*;
#(
    parameter int CHAIN_LEN = 92,
    parameter int CRC_W     = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 scan_en,
    input  logic                 scan_in,
    output logic                 scan_out,
    input  logic                 cfg_lock,
    output logic [CHAIN_LEN-1:0] cfg_q,
    output logic                 cfg_valid,
    output logic                 cfg_update,
    output logic                 cfg_err
);

    localparam int FRAME_LEN = frame_len(CHAIN_LEN, CRC_W);
    localparam int CNT_W     = $clog2(FRAME_LEN + 2);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_LEN);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FRAME_LEN + 1);

    state_e               state_q;
    state_e               state_d;
    logic [FRAME_LEN-1:0] sr_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [CRC_W-1:0]     crc;
    logic                 start;
    logic                 shift;
    logic                 commit;
    logic                 check_fail;

    crc_serial #(
        .CRC_W (CRC_W)
    ) u_crc (
        .clk      (clk),
        .reset    (reset),
        .clr      (start),
        .en       (shift),
        .data_bit (scan_in),
        .crc      (crc)
    );

    // A rise in PEND abandons the pending frame exactly like a rise in IDLE
    always_comb begin
        state_d    = state_q;
        start      = 1'b0;
        commit     = 1'b0;
        check_fail = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (scan_en) begin
                    start   = 1'b1;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (!scan_en) state_d = ST_CHECK;
            end
            ST_CHECK: begin
                if (cnt_q == CNT_FULL && crc == '0) begin
                    state_d = ST_PEND;
                end else begin
                    check_fail = 1'b1;
                    state_d    = ST_IDLE;
                end
            end
            ST_PEND: begin
                if (scan_en) begin
                    start   = 1'b1;
                    state_d = ST_SHIFT;
                end else if (!cfg_lock) begin
                    commit  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        shift = start | (state_q == ST_SHIFT && scan_en);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            sr_q       <= '0;
            cnt_q      <= '0;
            cfg_q      <= '0;
            cfg_valid  <= 1'b0;
            cfg_update <= 1'b0;
            cfg_err    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cfg_update <= commit;
            if (shift) sr_q <= {sr_q[FRAME_LEN-2:0], scan_in};
            // saturating one past full so overlength never aliases a good length
            if (start) begin
                cnt_q <= CNT_W'(1);
            end else if (shift && cnt_q != CNT_SAT) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
            if (start) begin
                cfg_err <= 1'b0;
            end else if (check_fail) begin
                cfg_err <= 1'b1;
            end
            if (commit) begin
                cfg_q     <= sr_q[FRAME_LEN-1:CRC_W];
                cfg_valid <= 1'b1;
            end
        end
    end

    assign scan_out = sr_q[FRAME_LEN-1];

endmodule

// File: tb/tb_cfg_scan_chain.sv
// Directed bench for cfg_scan_chain with a frame-level reference model.
module tb_cfg_scan_chain;

    localparam int CL = 16;
    localparam int CW = 8;
    localparam int FL = CL + CW;

    logic          clk = 1'b0;
    logic          reset;
    logic          scan_en;
    logic          scan_in;
    logic          scan_out;
    logic          cfg_lock;
    logic [CL-1:0] cfg_q;
    logic          cfg_valid;
    logic          cfg_update;
    logic          cfg_err;

    always #5 clk = ~clk;

    cfg_scan_chain #(.CHAIN_LEN(CL), .CRC_W(CW)) dut (
        .clk        (clk),
        .reset      (reset),
        .scan_en    (scan_en),
        .scan_in    (scan_in),
        .scan_out   (scan_out),
        .cfg_lock   (cfg_lock),
        .cfg_q      (cfg_q),
        .cfg_valid  (cfg_valid),
        .cfg_update (cfg_update),
        .cfg_err    (cfg_err)
    );

    int vectors     = 0;
    int miscompares = 0;
    bit cmp_on      = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // CRC-8 poly 0x07, init 0, over the low n bits of v, oldest bit first
    function automatic logic [7:0] crc8(input logic [63:0] v, input int n);
        logic [7:0] c;
        logic       fb;
        c = 8'h00;
        for (int i = n - 1; i >= 0; i--) begin
            fb = c[7] ^ v[i];
            c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
        end
        return c;
    endfunction

    function automatic logic [FL-1:0] mk(input logic [CL-1:0] d);
        return {d, crc8({48'h0, d}, CL)};
    endfunction

    // Frame-level reference: collects each frame's bits, judges it whole at its end
    logic [FL-1:0] m_sr;
    logic [CL-1:0] m_q;
    logic [CL-1:0] m_pdata;
    logic          m_valid, m_upd, m_err;
    logic [63:0]   fbits;
    int            flen;
    bit            in_frame, check_due, pending;

    always @(posedge clk) begin
        if (reset) begin
            m_sr = '0; m_q = '0; m_valid = 0; m_upd = 0; m_err = 0;
            in_frame = 0; check_due = 0; pending = 0; flen = 0; fbits = '0;
        end else begin
            m_upd = 0;
            if (check_due) begin
                check_due = 0;
                if (flen == FL && crc8(fbits, flen) == 8'h00) begin
                    pending = 1;
                    m_pdata = fbits[FL-1:CW];
                end else begin
                    m_err = 1;
                end
            end else if (in_frame && !scan_en) begin
                in_frame  = 0;
                check_due = 1;
            end else if (scan_en) begin
                if (!in_frame) begin
                    in_frame = 1; pending = 0; m_err = 0; flen = 0; fbits = '0;
                end
                fbits = {fbits[62:0], scan_in};
                if (flen < 64) flen++;
                m_sr = {m_sr[FL-2:0], scan_in};
            end else if (pending && !cfg_lock) begin
                m_q = m_pdata; m_valid = 1; m_upd = 1; pending = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_on) begin
            chk("cfg_q",      32'(cfg_q),      32'(m_q));
            chk("cfg_valid",  32'(cfg_valid),  32'(m_valid));
            chk("cfg_update", 32'(cfg_update), 32'(m_upd));
            chk("cfg_err",    32'(cfg_err),    32'(m_err));
            chk("scan_out",   32'(scan_out),   32'(m_sr[FL-1]));
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Leaves scan_en low at a negedge; the following posedge is the fall edge
    task automatic send_frame(input logic [31:0] v, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            scan_en = 1'b1;
            scan_in = v[n-1-i];
        end
        @(negedge clk);
        scan_en = 1'b0;
        scan_in = 1'b0;
    endtask

    initial begin
        logic [FL-1:0] f;
        reset = 1'b1; scan_en = 1'b0; scan_in = 1'b0; cfg_lock = 1'b0;
        idle(3);
        chk("rst_cfg_q", 32'(cfg_q), 32'h0);
        chk("rst_flags", {29'h0, cfg_valid, cfg_update, cfg_err}, 32'h0);
        chk("rst_scan_out", 32'(scan_out), 32'h0);
        reset = 1'b0;
        cmp_on = 1'b1;

        chk("model_crc_a5c3", 32'(crc8({48'h0, 16'hA5C3}, 16)), 32'h1E);
        chk("model_residue", 32'(crc8({40'h0, 24'hA5C31E}, 24)), 32'h0);
        idle(2);

        // good frame, exact commit timing
        f = mk(16'hA5C3);
        send_frame(32'(f), FL);
        idle(1);
        chk("good_hold1", 32'(cfg_q), 32'h0);
        chk("good_readback", 32'(scan_out), 32'h1);
        idle(1);
        chk("good_hold2", 32'(cfg_q), 32'h0);
        idle(1);
        chk("good_cfg_q", 32'(cfg_q), 32'hA5C3);
        chk("good_flags", {29'h0, cfg_valid, cfg_update, cfg_err}, 32'b110);
        idle(1);
        chk("good_upd_single", 32'(cfg_update), 32'h0);
        idle(3);

        // last CRC bit flipped
        send_frame(32'(f ^ 24'h1), FL);
        idle(2);
        chk("badcrc_err", 32'(cfg_err), 32'h1);
        idle(2);
        chk("badcrc_cfg_q", 32'(cfg_q), 32'hA5C3);
        idle(2);

        // short and long frames, each followed by a good frame
        send_frame(32'(f >> 1), FL - 1);
        idle(4);
        chk("short_err", 32'(cfg_err), 32'h1);
        send_frame(32'(mk(16'h5A0F)), FL);
        idle(4);
        chk("short_recover", {15'h0, cfg_q, cfg_err}, {15'h0, 16'h5A0F, 1'b0});
        send_frame({7'h0, f, 1'b1}, FL + 1);
        idle(4);
        chk("long_err", 32'(cfg_err), 32'h1);
        send_frame({6'h0, f, 2'b00}, FL + 2);
        idle(4);
        chk("long2_err", 32'(cfg_err), 32'h1);
        send_frame(32'(mk(16'hC001)), FL);
        idle(4);
        chk("long_recover", {15'h0, cfg_q, cfg_err}, {15'h0, 16'hC001, 1'b0});

        // commit held off by cfg_lock
        cfg_lock = 1'b1;
        send_frame(32'(mk(16'h3C96)), FL);
        idle(50);
        chk("lock_hold", 32'(cfg_q), 32'hC001);
        cfg_lock = 1'b0;
        idle(1);
        chk("lock_release", {15'h0, cfg_q, cfg_update}, {15'h0, 16'h3C96, 1'b1});
        idle(3);

        // reset in the middle of a shift
        f = mk(16'h0F0F);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            scan_en = 1'b1;
            scan_in = f[FL-1-i];
        end
        @(negedge clk);
        reset = 1'b1;
        idle(1);
        chk("midrst_cfg_q", 32'(cfg_q), 32'h0);
        chk("midrst_flags", {28'h0, scan_out, cfg_valid, cfg_update, cfg_err}, 32'h0);
        reset = 1'b0; scan_en = 1'b0; scan_in = 1'b0;
        idle(3);
        send_frame(32'(mk(16'h6B1D)), FL);
        idle(4);
        chk("postrst_commit", {15'h0, cfg_q, cfg_valid}, {15'h0, 16'h6B1D, 1'b1});

        // second frame replaces one still pending
        cfg_lock = 1'b1;
        send_frame(32'(mk(16'hBEEF)), FL);
        idle(5);
        send_frame(32'(mk(16'h1234)), FL);
        idle(6);
        chk("pend_hold", 32'(cfg_q), 32'h6B1D);
        cfg_lock = 1'b0;
        idle(1);
        chk("pend_replace", 32'(cfg_q), 32'h1234);
        idle(4);
        chk("pend_final", 32'(cfg_q), 32'h1234);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
